// File: rtl/seg_display_formatter.sv
// Seven-segment display formatter: selects a source, converts it to BCD
// with an iterative double-dabble engine, and formats per-digit codes.
// Ports: clk, reset (sync, active-high), sel, values, signed_mask, start
//        -> digits (4-bit codes, digit k at [k*4 +: 4]), busy, valid, overflow.
// Codes: 0-9 numeral, 10 blank, 11 dash/separator, 12 minus.
module seg_display_formatter #(
   parameter int NUM_DIGITS  = 6,
   parameter int DATA_W      = 32,
   parameter int NUM_SRC     = 4,
   parameter int SEL_W       = 4,
   parameter int REFRESH_CYC = 5000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_SRC*DATA_W-1:0] values,
   input  logic [NUM_SRC-1:0]        signed_mask,
   input  logic                      start,
   output logic [NUM_DIGITS*4-1:0]   digits,
   output logic                      busy,
   output logic                      valid,
   output logic                      overflow
);

   localparam int FW    = NUM_DIGITS - 2;
   // ceil(DATA_W * log10(2)) decimal digits
   localparam int BCD_N = (DATA_W * 30103 + 99999) / 100000;
   localparam int BW    = BCD_N * 4;
   localparam int PN    = (FW > BCD_N) ? FW : BCD_N;
   localparam int SW    = $clog2(DATA_W + 1);
   localparam int RC    = (REFRESH_CYC > 0) ? REFRESH_CYC : 1;
   localparam int CW    = (RC > 1) ? $clog2(RC) : 1;

   localparam logic [3:0] D_BLANK = 4'd10;
   localparam logic [3:0] D_DASH  = 4'd11;
   localparam logic [3:0] D_MINUS = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_CONV,
      S_FMT
   } state_t;

   state_t                  state_q, state_d;
   logic                    pend_q, pend_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SW-1:0]           step_q, step_d;
   logic [DATA_W-1:0]       mag_q, mag_d;
   logic [BW-1:0]           bcd_q, bcd_d;
   logic                    neg_q, neg_d;
   logic                    inv_q, inv_d;
   logic [NUM_DIGITS*4-1:0] digits_q, digits_d;
   logic                    ovf_q, ovf_d;

   logic                    ref_trig;
   logic                    trig;
   logic [DATA_W-1:0]       val_sel;
   logic                    sgn_sel;
   logic                    inv_sel;
   logic [BW-1:0]           bcd_adj;
   logic [BW-1:0]           bcd_sh;
   logic [DATA_W-1:0]       mag_sh;
   logic [PN*4-1:0]         bcd_pad;
   logic                    hi_pos;
   logic                    hi_neg;
   int                      msd;
   logic [NUM_DIGITS*4-1:0] fmt;
   logic                    fmt_ovf;

   // Periodic refresh; a zero period disables it.
   assign ref_trig = (REFRESH_CYC != 0) && (cnt_q == CW'(RC - 1));
   assign cnt_d    = ref_trig ? '0 : cnt_q + CW'(1);

   // The shadow is only written at the end of LOAD, so a select change
   // seen during LOAD is the one being captured and must not re-trigger.
   assign trig = start | ref_trig
               | ((sel != sel_q) && (state_q != S_LOAD));

   always_comb begin
      val_sel = '0;
      sgn_sel = 1'b0;
      inv_sel = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            val_sel = values[i*DATA_W +: DATA_W];
            sgn_sel = signed_mask[i];
            inv_sel = 1'b0;
         end
      end
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < BCD_N; k++) begin
         if (bcd_q[k*4 +: 4] >= 4'd5) begin
            bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
         end
      end
      {bcd_sh, mag_sh} = {bcd_adj, mag_q} << 1;
   end

   // Formatting works on the result of the final shift so the digit
   // register is loaded on the edge that enters FORMAT.
   always_comb begin
      bcd_pad = (PN*4)'(bcd_sh);
      hi_pos  = 1'b0;
      hi_neg  = 1'b0;
      msd     = 0;
      for (int k = 0; k < PN; k++) begin
         if (bcd_pad[k*4 +: 4] != 4'd0) begin
            if (k >= FW)     hi_pos = 1'b1;
            if (k >= FW - 1) hi_neg = 1'b1;
            if (k < FW)      msd = k;
         end
      end
      fmt_ovf = neg_q ? hi_neg : hi_pos;
      fmt     = '0;
      for (int k = 0; k < FW; k++) begin
         if (fmt_ovf) begin
            fmt[k*4 +: 4] = D_DASH;
         end else if (k <= msd) begin
            fmt[k*4 +: 4] = bcd_pad[k*4 +: 4];
         end else if (neg_q && (k == msd + 1)) begin
            fmt[k*4 +: 4] = D_MINUS;
         end else begin
            fmt[k*4 +: 4] = D_BLANK;
         end
      end
      fmt[FW*4 +: 4]             = D_DASH;
      fmt[(NUM_DIGITS-1)*4 +: 4] = 4'(sel_q);
      if (inv_q) begin
         fmt     = {NUM_DIGITS{D_BLANK}};
         fmt_ovf = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      sel_d    = sel_q;
      step_d   = step_q;
      mag_d    = mag_q;
      bcd_d    = bcd_q;
      neg_d    = neg_q;
      inv_d    = inv_q;
      digits_d = digits_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (pend_q || trig) begin
               state_d = S_LOAD;
               pend_d  = 1'b0;
            end
         end
         S_LOAD: begin
            sel_d   = sel;
            inv_d   = inv_sel;
            neg_d   = sgn_sel & val_sel[DATA_W-1];
            mag_d   = (sgn_sel & val_sel[DATA_W-1]) ? -val_sel : val_sel;
            bcd_d   = '0;
            step_d  = '0;
            state_d = S_CONV;
            if (trig) pend_d = 1'b1;
         end
         S_CONV: begin
            bcd_d  = bcd_sh;
            mag_d  = mag_sh;
            step_d = step_q + SW'(1);
            if (step_q == SW'(DATA_W - 1)) begin
               state_d  = S_FMT;
               digits_d = fmt;
               ovf_d    = fmt_ovf;
            end
            if (trig) pend_d = 1'b1;
         end
         S_FMT: begin
            state_d = S_IDLE;
            if (trig) pend_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pend_q   <= 1'b1;
         sel_q    <= '0;
         cnt_q    <= '0;
         step_q   <= '0;
         mag_q    <= '0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         inv_q    <= 1'b0;
         digits_q <= {NUM_DIGITS{D_BLANK}};
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         mag_q    <= mag_d;
         bcd_q    <= bcd_d;
         neg_q    <= neg_d;
         inv_q    <= inv_d;
         digits_q <= digits_d;
         ovf_q    <= ovf_d;
      end
   end

   assign digits   = digits_q;
   assign busy     = (state_q != S_IDLE);
   assign valid    = (state_q == S_FMT);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_display_formatter.sv
// Testbench for seg_display_formatter: directed vectors with hand-computed
// digit codes, latency, trigger merging, reset abort and periodic refresh.
module tb_seg_display_formatter;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   sel;
   logic [127:0] values;
   logic [3:0]   mask;
   logic         start;
   logic [23:0]  digits;
   logic         busy, valid, overflow;

   logic         r_reset;
   logic [3:0]   r_sel;
   logic [127:0] r_values;
   logic [3:0]   r_mask;
   logic         r_start;
   logic [23:0]  r_digits;
   logic         r_busy, r_valid, r_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg_display_formatter u_dut (
      .clk(clk), .reset(reset), .sel(sel), .values(values),
      .signed_mask(mask), .start(start), .digits(digits),
      .busy(busy), .valid(valid), .overflow(overflow)
   );

   seg_display_formatter #(.REFRESH_CYC(100)) u_ref (
      .clk(clk), .reset(r_reset), .sel(r_sel), .values(r_values),
      .signed_mask(r_mask), .start(r_start), .digits(r_digits),
      .busy(r_busy), .valid(r_valid), .overflow(r_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [3:0] s, input bit pulse,
                      output logic [23:0] d, output logic ov,
                      output bit ok);
      ok = 1'b0;
      d  = 'x;
      ov = 1'bx;
      sel = s;
      start = pulse;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (valid === 1'b1) begin
            ok = 1'b1;
            d  = digits;
            ov = overflow;
         end else begin
            tick();
         end
      end
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sel = 4'd0;
      values = '0;
      values[0 +: 32] = 32'd1234;
      mask = 4'b0000;
      start = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (digits !== 24'hAAAAAA) begin
         n_bad++;
         $display("FAIL reset_digits got %h want aaaaaa", digits);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      n_cmp++;
      if (valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid got %b want 0", valid);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ovf got %b want 0", overflow);
      end
   endtask

   task automatic test_first();
      bit early;
      reset = 1'b0;
      tick();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL first_busy1 got %b want 1", busy);
      end
      early = 1'b0;
      for (int c = 2; c <= 33; c++) begin
         tick();
         if (valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
      end
      n_cmp++;
      if (early !== 1'b0) begin
         n_bad++;
         $display("FAIL first_early got %b want 0", early);
      end
      tick();
      n_cmp++;
      if (valid !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL first_valid34 got v%b b%b want v1 b1", valid, busy);
      end
      n_cmp++;
      if (digits !== 24'h0B1234 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL first_digits got %h/%b want 0b1234/0", digits, overflow);
      end
      tick();
      n_cmp++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL first_end35 got v%b b%b want v0 b0", valid, busy);
      end
   endtask

   task automatic test_unsigned();
      logic [23:0] d;
      logic ov;
      bit ok;
      values[32 +: 32] = 32'd7;
      run(4'd1, 1'b0, d, ov, ok);
      n_cmp++;
      if (!ok || d !== 24'h1BAAA7 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL uns_7 got %h/%b ok%b want 1baaa7/0", d, ov, ok);
      end
      values[32 +: 32] = 32'd0;
      run(4'd1, 1'b1, d, ov, ok);
      n_cmp++;
      if (!ok || d !== 24'h1BAAA0 || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL uns_0 got %h/%b ok%b want 1baaa0/0", d, ov, ok);
      end
   endtask

   task automatic test_signed();
      logic [31:0] tv [6] = '{32'hFFFF_FFD3, 32'hFFFF_FC19, 32'hFFFF_FFFB,
                              32'd45, 32'hFFFF_FC18, 32'h8000_0000};
      logic [23:0] te [6] = '{24'h2BAC45, 24'h2BC999, 24'h2BAAC5,
                              24'h2BAA45, 24'h2BBBBB, 24'h2BBBBB};
      logic        to [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [23:0] d;
      logic ov;
      bit ok;
      mask = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         values[64 +: 32] = tv[i];
         run(4'd2, i != 0, d, ov, ok);
         n_cmp++;
         if (!ok || d !== te[i] || ov !== to[i]) begin
            n_bad++;
            $display("FAIL signed_%0d got %h/%b ok%b want %h/%b",
                     i, d, ov, ok, te[i], to[i]);
         end
      end
   endtask

   task automatic test_field_limits();
      logic [31:0] tv [4] = '{32'd9999, 32'd1000, 32'd10000, 32'hFFFF_FFFF};
      logic [23:0] te [4] = '{24'h3B9999, 24'h3B1000, 24'h3BBBBB, 24'h3BBBBB};
      logic        to [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [23:0] d;
      logic ov;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         values[96 +: 32] = tv[i];
         run(4'd3, i != 0, d, ov, ok);
         n_cmp++;
         if (!ok || d !== te[i] || ov !== to[i]) begin
            n_bad++;
            $display("FAIL field_%0d got %h/%b ok%b want %h/%b",
                     i, d, ov, ok, te[i], to[i]);
         end
      end
      values[96 +: 32] = 32'd10000;
      run(4'd3, 1'b1, d, ov, ok);
   endtask

   task automatic test_reset_mid();
      int first;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_busy got %b want 1", busy);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if (digits !== 24'hAAAAAA || busy !== 1'b0 ||
          valid !== 1'b0 || overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset got %h b%b v%b o%b want aaaaaa b0 v0 o0",
                  digits, busy, valid, overflow);
      end
      tick();
      reset = 1'b0;
      first = -1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (valid === 1'b1 && first < 0) begin
            first = c;
            n_cmp++;
            if (digits !== 24'h3BBBBB || overflow !== 1'b1) begin
               n_bad++;
               $display("FAIL mid_after got %h/%b want 3bbbbb/1",
                        digits, overflow);
            end
         end
      end
      n_cmp++;
      if (first != 34) begin
         n_bad++;
         $display("FAIL mid_latency got %0d want 34", first);
      end
   endtask

   task automatic test_invalid_sel();
      logic [23:0] d;
      logic ov;
      bit ok;
      run(4'd7, 1'b0, d, ov, ok);
      n_cmp++;
      if (!ok || d !== 24'hAAAAAA || ov !== 1'b0) begin
         n_bad++;
         $display("FAIL inv_sel got %h/%b ok%b want aaaaaa/0", d, ov, ok);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      int t [4];
      cnt = 0;
      for (int c = 0; c < 150; c++) begin
         start = (c == 0 || c == 5 || c == 10 || c == 15);
         tick();
         if (valid === 1'b1) begin
            if (cnt < 4) t[cnt] = c + 1;
            cnt++;
         end
      end
      start = 1'b0;
      n_cmp++;
      if (cnt != 2) begin
         n_bad++;
         $display("FAIL b2b_count got %0d want 2", cnt);
      end
      n_cmp++;
      if (cnt < 2 || t[0] != 34 || t[1] - t[0] != 35) begin
         n_bad++;
         $display("FAIL b2b_timing got %0d,%0d want 34,69", t[0], t[1]);
      end
   endtask

   task automatic test_snapshot();
      bit ok;
      values[96 +: 32] = 32'd42;
      sel = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      values[96 +: 32] = 32'd55;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (valid === 1'b1) ok = 1'b1;
         else tick();
      end
      n_cmp++;
      if (!ok || digits !== 24'h3BAA42) begin
         n_bad++;
         $display("FAIL snapshot got %h ok%b want 3baa42", digits, ok);
      end
      tick();
   endtask

   task automatic test_coincident();
      int cnt;
      logic [23:0] d;
      cnt = 0;
      d = 'x;
      sel = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 120; c++) begin
         if (valid === 1'b1) begin
            cnt++;
            d = digits;
         end
         tick();
      end
      n_cmp++;
      if (cnt != 1 || d !== 24'h0B1234) begin
         n_bad++;
         $display("FAIL coincident got %0d pulses %h want 1 0b1234", cnt, d);
      end
   endtask

   task automatic test_refresh();
      int cnt;
      int t [6];
      bit same;
      r_reset = 1'b1;
      repeat (2) tick();
      r_reset = 1'b0;
      cnt = 0;
      same = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         tick();
         if (r_valid === 1'b1) begin
            if (cnt < 6) t[cnt] = c;
            cnt++;
            if (r_digits !== 24'h0BAA77 || r_ovf !== 1'b0) same = 1'b0;
         end
      end
      n_cmp++;
      if (cnt != 4) begin
         n_bad++;
         $display("FAIL refresh_count got %0d want 4", cnt);
      end
      n_cmp++;
      if (cnt < 4 || t[0] != 34 || t[1] != 133 ||
          t[2] - t[1] != 100 || t[3] - t[2] != 100) begin
         n_bad++;
         $display("FAIL refresh_times got %0d,%0d,%0d,%0d want 34,133,233,333",
                  t[0], t[1], t[2], t[3]);
      end
      n_cmp++;
      if (same !== 1'b1) begin
         n_bad++;
         $display("FAIL refresh_digits got %b want 1", same);
      end
   endtask

   initial begin
      r_reset = 1'b1;
      r_sel = 4'd0;
      r_values = '0;
      r_values[0 +: 32] = 32'd77;
      r_mask = 4'b0000;
      r_start = 1'b0;
      test_reset();
      test_first();
      test_unsigned();
      test_signed();
      test_field_limits();
      test_reset_mid();
      test_invalid_sel();
      test_back_to_back();
      test_snapshot();
      test_coincident();
      test_refresh();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
